// File: rtl/sevenseg_pkg.sv
// Types shared between the seven-segment scan driver and its receive-side capture.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [6:0] seg_t;

    typedef enum logic [0:0] {
        TRACK = 1'b0,
        HELD  = 1'b1
    } rx_state_t;

    // Synchronized pin snapshot, field order matches the {an, segs, dp} vector
    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        seg_t                  segs;
        logic                  dp;
    } pins_t;

endpackage

// File: rtl/sevenseg_rx_enc.sv
// Active-low 8->3 anode encoder, inverse of the driver's 3->8 anode decoder.
// Latency: combinational.
// Backpressure: none.
module enc_8_3_n
    import sevenseg_pkg::*;
(
    input  logic [NUM_DIGITS-1:0] an_n,
    output logic [2:0]            idx,
    output logic                  one_hot,
    output logic                  none
);

    logic [NUM_DIGITS-1:0] low;

    assign low     = ~an_n;
    assign one_hot = (low != '0) && ((low & (low - NUM_DIGITS'(1))) == '0);
    assign none    = &an_n;

    // Lowest active anode wins; only meaningful when one_hot is set
    always_comb begin
        idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!an_n[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/sevenseg_rx.sv
// Rebuilds per-digit segment/dp registers from a scanned active-low display bus.
// Latency: a steady pin change lands on digit/valid at edge 2+STABLE_CYCLES.
// Backpressure: none; outputs are free-running registers and one-cycle strobes.
module sevenseg_rx
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] an_n,
    input  seg_t                  segs_n,
    input  logic                  dp_n,
    output seg_t [NUM_DIGITS-1:0] digit,
    output logic [NUM_DIGITS-1:0] dp,
    output logic [NUM_DIGITS-1:0] valid,
    output logic                  frame_stb,
    output logic                  multi_err,
    output logic                  timeout_stb
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    pins_t                 p_meta, p_sync, p_prev;
    rx_state_t             state;
    logic [CW-1:0]         cnt;
    logic [TW-1:0]         tmo_cnt;
    logic [NUM_DIGITS-1:0] seen, seen_set;
    logic [2:0]            cap_idx;
    logic                  one_hot, none;
    logic                  changed, eval, cap, multi;

    enc_8_3_n u_enc (
        .an_n    (p_sync.an),
        .idx     (cap_idx),
        .one_hot (one_hot),
        .none    (none)
    );

    assign changed  = (p_sync != p_prev);
    // Evaluate on the edge where the count reaches STABLE_CYCLES-1, i.e. the
    // STABLE_CYCLES-th identical sample
    assign eval     = (state == TRACK) && !changed && (cnt == CNT_FIRE);
    assign cap      = eval && one_hot;
    assign multi    = eval && !one_hot && !none;
    assign seen_set = seen | (NUM_DIGITS'(1) << cap_idx);

    // Idle bus reset value keeps the first post-reset samples blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_meta <= '1;
            p_sync <= '1;
            p_prev <= '1;
        end else begin
            p_meta <= {an_n, segs_n, dp_n};
            p_sync <= p_meta;
            p_prev <= p_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TRACK;
            cnt   <= '0;
        end else begin
            if (changed) begin
                state <= TRACK;
                cnt   <= '0;
            end else begin
                if (eval) state <= HELD;
                if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit       <= '0;
            dp          <= '0;
            valid       <= '0;
            seen        <= '0;
            tmo_cnt     <= '0;
            frame_stb   <= 1'b0;
            multi_err   <= 1'b0;
            timeout_stb <= 1'b0;
        end else begin
            frame_stb   <= cap && (&seen_set);
            multi_err   <= multi;
            timeout_stb <= 1'b0;
            if (cap) begin
                digit[cap_idx] <= ~p_sync.segs;
                dp[cap_idx]    <= ~p_sync.dp;
                valid[cap_idx] <= 1'b1;
                seen           <= (&seen_set) ? '0 : seen_set;
                tmo_cnt        <= '0;
            end else if (valid != '0) begin
                // Timer only runs while something is valid to expire
                if (tmo_cnt == TMO_LAST) begin
                    valid       <= '0;
                    seen        <= '0;
                    tmo_cnt     <= '0;
                    timeout_stb <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: doc/sevenseg_rx.md
# sevenseg_rx

Receive-side counterpart of the multiplexed eight-digit seven-segment driver. It samples a scanned, active-low anode/segment bus and rebuilds the per-digit segment patterns and decimal points as stable parallel registers. Its uses are loopback self-test of the display controller and capture of an external scanned display. It sits between the board pins (or the driver's outputs in loopback) and any checker or logic that consumes the digits.

## Interface
- `STABLE_CYCLES`, default 16: consecutive identical synchronized samples required before a capture (≥2).
- `TIMEOUT_CYCLES`, default 1048576: cycles without a capture before all digits are invalidated (≥STABLE_CYCLES+4).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `an_n` in 8: anode selects, active-low, asynchronous to `clk`.
- `segs_n` in 7: segments a..g, active-low, bit 0 = a.
- `dp_n` in 1: decimal point, active-low.
- `digit` out 8×7: captured segment pattern per position, active-high; `digit[i]` belongs to `an_n[i]`.
- `dp` out 8: captured decimal point per position, active-high.
- `valid` out 8: position i has been captured since reset or since the last timeout.
- `frame_stb` out 1: one-cycle pulse when every position has been captured in the current frame.
- `multi_err` out 1: one-cycle pulse when a stable pattern has more than one anode low.
- `timeout_stb` out 1: one-cycle pulse when the timeout fires.

## Operation
- All 16 inputs pass through a 2-flop synchronizer. The synchronized vector `{an, segs, dp}` is called P.
- Stability counter `cnt`:
  - Cleared to 0 on any cycle where P differs from the previous P.
  - Otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - **TRACK** (reset state): waiting for P to stabilize.
    - When `cnt` reaches STABLE_CYCLES−1 with P unchanged, the FSM evaluates P on that edge and goes to **HELD**.
    - Exactly one anode low at index i: write `~segs_n` to `digit[i]`, write `~dp_n` to `dp[i]`, set `valid[i]`, set `seen[i]`.
    - Two or more anodes low: no write; pulse `multi_err`.
    - All anodes high (blanking): no write and no error.
  - **HELD**: waiting for P to change. Any change in P returns the FSM to TRACK. Each stable pattern is evaluated at most once.
- Frame tracking:
  - A capture that makes `seen` all ones pulses `frame_stb` on the following cycle.
  - The same edge clears `seen` to 0; the completing capture counts toward the finished frame only.
  - Recaptures of a position already in `seen` are allowed; they update the data but do not advance the frame.
- Timeout counter:
  - Counts cycles since the last single-anode capture; multi-anode and blank patterns do not reset it.
  - On reaching TIMEOUT_CYCLES−1, the next edge clears `valid` and `seen` and pulses `timeout_stb`. `digit` and `dp` hold their values. The counter restarts from 0.
- A capture and a timeout on the same edge: the capture wins. Its bit is set, the timeout is suppressed, and the counter resets.

## Timing
- Reset values (all asynchronous):
  - `digit` = 0, `dp` = 0, `valid` = 0, `seen` = 0.
  - All strobes 0, `cnt` = 0, timeout counter = 0, FSM = TRACK.
  - Synchronizer flops reset to all ones, i.e. the idle bus.
- Latency: a pin change held steady becomes visible on `digit`/`valid` at clock edge 2 + STABLE_CYCLES after the first edge that samples it.
- `frame_stb`, `multi_err` and `timeout_stb` are registered, exactly one cycle wide, and never asserted on consecutive cycles for the same event.
- A pattern stable for fewer than STABLE_CYCLES samples is never captured. This is the ghosting rejection at anode transitions.
- Reset asserted mid-capture returns every output to its reset value immediately. Partial frame state is discarded.

## Structure
- Package `sevenseg_pkg` holds:
  - `NUM_DIGITS = 8`
  - `seg_t` (`logic [6:0]`)
  - the FSM enum `rx_state_t` {TRACK, HELD}
  - shared with the driver side.
- Sub-module `enc_8_3_n`: an active-low 8→3 anode encoder, the inverse of the driver's 3→8 decoder. Outputs: `idx[2:0]`, `one_hot` (exactly one low) and `none` (all high).
- The synchronizer, counters, FSM and capture registers live in `sevenseg_rx`.

## Test plan (STABLE_CYCLES=4, TIMEOUT_CYCLES=64)
- Reset → all outputs 0; idle bus (all inputs high) held for 100 cycles → no strobe, `valid`=0.
- `an_n`=8'b1111_1011, `segs_n`=7'b0100100, `dp_n`=0 held for 10 cycles → `digit[2]`=7'h5B, `dp[2]`=1, `valid`=8'h04, captured at edge 6.
- Scan all 8 positions, each held 8 cycles, with distinct codes → all `digit` values match and `valid`=8'hFF. `frame_stb` pulses once, one cycle after the position-7 capture; a second full scan gives a second pulse.
- Anode held 3 cycles, then switched → no capture of the short pattern; `valid` unchanged.
- `an_n`=8'b1111_0011 held for 10 cycles → `multi_err` pulses once and no `digit` changes.
- Capture one digit, then idle for 64 cycles → `timeout_stb` pulses, `valid`=0, `digit` retained. Assert `rst_n` during a scan → all outputs 0 asynchronously.
